intf_array_fifo_bridge: RTL and testbench
=========================================

Name: intf_array_fifo_bridge

Overview:
- N-lane buffered bridge between two arrays of handshake interfaces.
- Each lane has an independent DEPTH-entry FIFO with valid/ready flow control on both sides.
- Replaces the unbuffered per-lane wiring between source and sink interface arrays. Adds per-lane occupancy, flush and full/empty status.
- Sits between a lane producer array and a lane consumer array in the test top.

Parameters:
- N, 4, number of lanes; interface arrays and status vectors indexed [0:N-1], ascending.
- W, 8, data width per lane.
- DEPTH, 4, FIFO entries per lane; power of two, at least 2.
- CW, $clog2(DEPTH+1), occupancy counter width; derived, not overridable.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- up  sink-modport interface array  [0:N-1] of chan_if #(W)  upstream lanes: valid, data in; ready out.
- dn  source-modport interface array  [0:N-1] of chan_if #(W)  downstream lanes: valid, data out; ready in.
- flush  input  [0:N-1]  per-lane synchronous flush.
- full_vec  output  [0:N-1]  lane FIFO holds DEPTH entries.
- empty_vec  output  [0:N-1]  lane FIFO holds 0 entries.
- occ  output  [0:N-1][CW-1:0]  per-lane occupancy.
- xfer_cnt  output  16  total downstream transfers (see Optional Feature).

Behaviour:
- Interface chan_if #(W): signals valid, ready, data[W-1:0].
  - Modport source: outputs valid, data; input ready.
  - Modport sink: inputs valid, data; output ready.
- Reset (rst_n low, asynchronous): every lane empty; occ=0; empty_vec all 1; full_vec all 0; dn[i].valid=0; dn[i].data=0; xfer_cnt=0.
  - up[i].ready is combinational from lane state, so it reads 1 while in reset.
  - Reset mid-transfer discards all stored data. No partial state survives.
- Push: up[i].valid && up[i].ready at posedge writes data at the lane write pointer.
  - up[i].ready = !full_vec[i] && !flush[i].
- Pop: dn[i].valid && dn[i].ready at posedge retires the head entry.
  - dn[i].valid = !empty_vec[i]; dn[i].data = head entry.
  - Read port is registered memory or a head register; data must be stable while valid && !ready.
- Latency: a word pushed into an empty lane at edge k is visible with dn valid after edge k. There is no same-cycle fall-through.
- Occupancy:
  - push only: occ+1; pop only: occ-1; push and pop together: occ unchanged, both pointers advance.
  - Full lane: ready=0, so no push; a pop the same cycle frees a slot visible on the next cycle.
  - Empty lane: no pop possible; a push the same cycle is not bypassed.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. full/empty derived from occ, not from pointer compare.
- Flush: flush[i] high at an edge clears that lane's pointers and occ.
  - Any coincident push or pop on that lane is ignored.
  - up[i].ready is low for the whole flush cycle.
  - Other lanes are unaffected.
- Lanes are fully independent; no cross-lane arbitration.
- Widths: occ saturates by construction, never exceeding DEPTH; no arithmetic overflow possible.

Optional Feature:
- Macro INTF_BRIDGE_XFER_CNT_EN.
- Defined: xfer_cnt increments by the number of lanes that popped in that cycle (0..N).
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the counter logic is not compiled and xfer_cnt is tied to 16'h0000. The port list is identical in both builds.

Decomposition:
- Package intf_bridge_pkg holds:
  - Lane data typedef parameterised via W (type parameter in the submodule).
  - Pointer and occupancy width functions.
  - Localparam XFER_CNT_W=16.
- chan_if lives in its own file next to the package. An interface cannot be placed in a package.
- One submodule, lane_fifo: a single-lane FIFO with push/pop/flush, data, full, empty and occ.
  - Top instantiates it N times in a generate loop and binds it to up[i]/dn[i].
  - Top also holds the optional transfer counter.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 words in lane 1 -> after release, occ[1]=0, empty_vec=4'b1111, dn[1].valid=0.
- Fill: lane 0 pushes 8'h11,22,33,44 with dn[0].ready=0 -> full_vec[0]=1, up[0].ready=0, occ[0]=4. Then hold ready=1 for 4 cycles -> outputs 11,22,33,44 in order, empty_vec[0]=1.
- Simultaneous push/pop: lane 2 at occ=2, push 8'hA5 and pop in the same cycle -> occ stays 2, head advances, A5 emerges third.
- Wrap-around: 10 words (0x00..0x09) streamed through lane 3 with ready toggling 1/0 -> output order 0x00..0x09 intact, occ never exceeds 4.
- Flush: lane 1 occ=3, flush[1]=1 with coincident up valid 8'hFF -> next cycle occ[1]=0, FF not stored, lanes 0/2/3 occ unchanged.
- Counter (macro defined): all 4 lanes pop every cycle for 5 cycles -> xfer_cnt=20. Preload near max via 16384 cycles of 4 pops -> xfer_cnt holds 16'hFFFF. Macro undefined -> xfer_cnt stays 0.

Source files
------------

// File: rtl/intf_array_fifo_bridge_pkg.sv
// intf_bridge_pkg: shared widths and constants for the N-lane FIFO bridge.
// No ports; provides pointer/occupancy width helpers and XFER_CNT_W.
package intf_bridge_pkg;
  localparam int XFER_CNT_W = 16;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/intf_array_fifo_bridge_if.sv
// chan_if: one valid/ready/data handshake lane.
// source drives valid/data and samples ready; sink is the mirror image.
interface chan_if #(parameter int W = 8);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  modport source(output valid, data, input ready);
  modport sink(input valid, data, output ready);
endinterface

// File: rtl/intf_array_fifo_bridge_lane_fifo.sv
// lane_fifo: single-lane DEPTH-entry FIFO with push/pop/flush and status.
// Ports: clk, rst_n (async active-low), flush; in_valid/in_ready/in_data
// (write side); out_valid/out_ready/out_data (read side); full, empty, occ.
module lane_fifo import intf_bridge_pkg::*; #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  parameter type data_t = logic [W-1:0],
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = occ_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  data_t         in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output data_t         out_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] occ
);
  data_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  assign full      = occ == CW'(DEPTH);
  assign empty     = occ == '0;
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  // head is read straight from the storage flops, so it holds while stalled
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) mem[wr_ptr] <= in_data;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/intf_array_fifo_bridge.sv
// intf_array_fifo_bridge: N independent buffered lanes between chan_if arrays.
// Ports: clk, rst_n (async active-low); up[0:N-1] (sink), dn[0:N-1] (source);
// flush[0:N-1]; full_vec, empty_vec, occ per lane; xfer_cnt (16-bit).
// Optional: define INTF_BRIDGE_XFER_CNT_EN to build the saturating transfer
// counter; otherwise xfer_cnt is tied to zero.
module intf_array_fifo_bridge import intf_bridge_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int CW = occ_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  chan_if.sink                  up [0:N-1],
  chan_if.source                dn [0:N-1],
  input  logic [0:N-1]          flush,
  output logic [0:N-1]          full_vec,
  output logic [0:N-1]          empty_vec,
  output logic [0:N-1][CW-1:0]  occ,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    lane_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush[i]),
      .in_valid (up[i].valid),
      .in_ready (up[i].ready),
      .in_data  (up[i].data),
      .out_valid(dn[i].valid),
      .out_ready(dn[i].ready),
      .out_data (dn[i].data),
      .full     (full_vec[i]),
      .empty    (empty_vec[i]),
      .occ      (occ[i])
    );
  end
`ifdef INTF_BRIDGE_XFER_CNT_EN
  localparam int SW = XFER_CNT_W + 1;
  logic [0:N-1]  pop_vec;
  logic [SW-1:0] sum;
  // a pop on a flushing lane is discarded, so it is not counted
  for (genvar j = 0; j < N; j++) begin : g_pop
    assign pop_vec[j] = dn[j].valid && dn[j].ready && !flush[j];
  end
  always_comb sum = {1'b0, xfer_cnt} + SW'($countones(pop_vec));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) xfer_cnt <= '0;
    else xfer_cnt <= sum[SW-1] ? '1 : sum[XFER_CNT_W-1:0];
`else
  assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_intf_array_fifo_bridge.sv
// tb_intf_array_fifo_bridge: scoreboard bench for the N-lane FIFO bridge.
module tb_intf_array_fifo_bridge;
  localparam int N = 4;
  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [0:N-1]         up_valid = '0, dn_ready = '0, flush = '0;
  logic [W-1:0]         up_data [N];
  logic [0:N-1]         up_ready, dn_valid, full_vec, empty_vec;
  logic [W-1:0]         dn_data [N];
  logic [0:N-1][CW-1:0] occ;
  logic [15:0]          xfer_cnt;

  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] got_q [N][$];
  int max_occ [N];
  int checks = 0;
  int errors = 0;

  chan_if #(W) up [0:N-1] ();
  chan_if #(W) dn [0:N-1] ();

  for (genvar i = 0; i < N; i++) begin : g_wire
    assign up[i].valid = up_valid[i];
    assign up[i].data  = up_data[i];
    assign up_ready[i] = up[i].ready;
    assign dn[i].ready = dn_ready[i];
    assign dn_valid[i] = dn[i].valid;
    assign dn_data[i]  = dn[i].data;
  end

  intf_array_fifo_bridge #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up       (up),
    .dn       (dn),
    .flush    (flush),
    .full_vec (full_vec),
    .empty_vec(empty_vec),
    .occ      (occ),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // One cycle: record accepted pushes as expectations and completed pops as
  // observations, then advance to the next negedge.
  task automatic tick();
    #1;
    for (int l = 0; l < N; l++) begin
      if (up_valid[l] && up_ready[l]) exp_q[l].push_back(up_data[l]);
      if (dn_valid[l] && dn_ready[l] && !flush[l]) got_q[l].push_back(dn_data[l]);
      if (int'(occ[l]) > max_occ[l]) max_occ[l] = int'(occ[l]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_queues();
    for (int l = 0; l < N; l++) begin
      exp_q[l].delete();
      got_q[l].delete();
      max_occ[l] = 0;
    end
  endtask

  task automatic idle();
    up_valid = '0;
    dn_ready = '0;
    flush = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (empty_vec !== 4'b1111 || full_vec !== 4'b0000 || occ !== '0 || dn_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: empty=%b full=%b occ=%h dn_valid=%b required 1111/0000/0/0000",
               empty_vec, full_vec, occ, dn_valid);
    end
    checks++;
    if (up_ready !== 4'b1111 || dn_data[2] !== 8'h00 || xfer_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_ready: up_ready=%b dn_data2=%h xfer=%h required 1111/00/0000",
               up_ready, dn_data[2], xfer_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    up_valid[1] = 1'b1;
    up_data[1] = 8'h5A;
    tick();
    up_data[1] = 8'h6B;
    tick();
    idle();
    checks++;
    if (occ[1] !== 3'd2) begin
      errors++;
      $display("FAIL reset_preload: occ1=%0d required 2", occ[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (occ[1] !== 3'd0 || empty_vec !== 4'b1111 || dn_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: occ1=%0d empty=%b dn_valid1=%b required 0/1111/0",
               occ[1], empty_vec, dn_valid[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (occ[1] !== 3'd0 || empty_vec !== 4'b1111 || dn_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: occ1=%0d empty=%b dn_valid1=%b required 0/1111/0",
               occ[1], empty_vec, dn_valid[1]);
    end
    clear_queues();
  endtask

  task automatic test_fill();
    logic [W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [W-1:0] g, e;
    for (int k = 0; k < 4; k++) begin
      up_valid[0] = 1'b1;
      up_data[0] = words[k];
      tick();
      if (k == 0) begin
        checks++;
        if (dn_valid[0] !== 1'b1 || dn_data[0] !== 8'h11) begin
          errors++;
          $display("FAIL fill_first: valid=%b data=%h required 1/11", dn_valid[0], dn_data[0]);
        end
      end
    end
    up_valid[0] = 1'b1;
    up_data[0] = 8'h99;
    #1;
    checks++;
    if (full_vec[0] !== 1'b1 || up_ready[0] !== 1'b0 || occ[0] !== 3'd4 || dn_data[0] !== 8'h11) begin
      errors++;
      $display("FAIL fill_full: full=%b ready=%b occ=%0d head=%h required 1/0/4/11",
               full_vec[0], up_ready[0], occ[0], dn_data[0]);
    end
    tick();
    up_valid[0] = 1'b0;
    dn_ready[0] = 1'b1;
    repeat (4) tick();
    idle();
    checks++;
    if (got_q[0].size() != 4 || exp_q[0].size() != 4 || empty_vec[0] !== 1'b1) begin
      errors++;
      $display("FAIL fill_count: got=%0d exp=%0d empty=%b required 4/4/1",
               got_q[0].size(), exp_q[0].size(), empty_vec[0]);
    end
    for (int k = 0; k < 4 && got_q[0].size() > 0 && exp_q[0].size() > 0; k++) begin
      g = got_q[0].pop_front();
      e = exp_q[0].pop_front();
      checks++;
      if (g !== e || g !== words[k]) begin
        errors++;
        $display("FAIL fill_data[%0d]: got %h required %h", k, g, words[k]);
      end
    end
    clear_queues();
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] g, e;
    up_valid[2] = 1'b1;
    up_data[2] = 8'h01;
    tick();
    up_data[2] = 8'h02;
    tick();
    up_data[2] = 8'hA5;
    dn_ready[2] = 1'b1;
    tick();
    up_valid[2] = 1'b0;
    dn_ready[2] = 1'b0;
    checks++;
    if (occ[2] !== 3'd2 || dn_data[2] !== 8'h02) begin
      errors++;
      $display("FAIL simul_occ: occ2=%0d head=%h required 2/02", occ[2], dn_data[2]);
    end
    dn_ready[2] = 1'b1;
    repeat (3) tick();
    idle();
    checks++;
    if (got_q[2].size() != 3 || exp_q[2].size() != 3) begin
      errors++;
      $display("FAIL simul_count: got=%0d exp=%0d required 3/3", got_q[2].size(), exp_q[2].size());
    end else if (got_q[2][2] !== 8'hA5) begin
      errors++;
      $display("FAIL simul_third: got %h required a5", got_q[2][2]);
    end
    while (got_q[2].size() > 0 && exp_q[2].size() > 0) begin
      g = got_q[2].pop_front();
      e = exp_q[2].pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL simul_data: got %h required %h", g, e);
      end
    end
    clear_queues();
  endtask

  task automatic test_wrap();
    int sent;
    int c;
    logic [W-1:0] g, e;
    sent = 0;
    c = 0;
    while ((sent < 10 || !empty_vec[3]) && c < 100) begin
      up_valid[3] = sent < 10;
      up_data[3] = W'(sent);
      dn_ready[3] = (c % 2) == 0;
      tick();
      sent = exp_q[3].size() + got_q[3].size() - got_q[3].size() + got_q[3].size() * 0;
      sent = exp_q[3].size();
      c++;
    end
    idle();
    checks++;
    if (c >= 100 || got_q[3].size() != 10 || exp_q[3].size() != 10) begin
      errors++;
      $display("FAIL wrap_count: cycles=%0d got=%0d exp=%0d required <100/10/10",
               c, got_q[3].size(), exp_q[3].size());
    end
    checks++;
    if (max_occ[3] != DEPTH) begin
      errors++;
      $display("FAIL wrap_maxocc: max occ %0d required %0d", max_occ[3], DEPTH);
    end
    for (int k = 0; got_q[3].size() > 0 && exp_q[3].size() > 0; k++) begin
      g = got_q[3].pop_front();
      e = exp_q[3].pop_front();
      checks++;
      if (g !== e || g !== W'(k)) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %h required %h", k, g, W'(k));
      end
    end
    clear_queues();
  endtask

  task automatic test_flush();
    logic [W-1:0] g, e;
    for (int k = 0; k < 3; k++) begin
      up_valid[1] = 1'b1;
      up_data[1] = W'(8'h70 + k);
      up_valid[0] = k == 0;
      up_data[0] = 8'hC0;
      up_valid[2] = k < 2;
      up_data[2] = W'(8'hD0 + k);
      tick();
    end
    idle();
    checks++;
    if (occ[1] !== 3'd3 || occ[0] !== 3'd1 || occ[2] !== 3'd2 || occ[3] !== 3'd0) begin
      errors++;
      $display("FAIL flush_pre: occ=%h required lanes 1/3/2/0", occ);
    end
    flush[1] = 1'b1;
    up_valid[1] = 1'b1;
    up_data[1] = 8'hFF;
    dn_ready[1] = 1'b1;
    #1;
    checks++;
    if (up_ready[1] !== 1'b0 || up_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: ready1=%b ready0=%b required 0/1", up_ready[1], up_ready[0]);
    end
    tick();
    exp_q[1].delete();
    flush[1] = 1'b0;
    up_valid[1] = 1'b0;
    dn_ready[1] = 1'b0;
    checks++;
    if (occ[1] !== 3'd0 || empty_vec[1] !== 1'b1 || occ[0] !== 3'd1 || occ[2] !== 3'd2 || occ[3] !== 3'd0) begin
      errors++;
      $display("FAIL flush_occ: occ=%h empty1=%b required lanes 1/0/2/0 and 1", occ, empty_vec[1]);
    end
    tick();
    checks++;
    if (occ[1] !== 3'd0 || dn_valid[1] !== 1'b0 || got_q[1].size() != 0) begin
      errors++;
      $display("FAIL flush_nostore: occ1=%0d valid1=%b pops=%0d required 0/0/0",
               occ[1], dn_valid[1], got_q[1].size());
    end
    dn_ready = '1;
    repeat (3) tick();
    idle();
    for (int l = 0; l < N; l++) begin
      checks++;
      if (got_q[l].size() != exp_q[l].size()) begin
        errors++;
        $display("FAIL flush_drain_count lane%0d: got %0d required %0d", l, got_q[l].size(), exp_q[l].size());
      end
      while (got_q[l].size() > 0 && exp_q[l].size() > 0) begin
        g = got_q[l].pop_front();
        e = exp_q[l].pop_front();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL flush_drain lane%0d: got %h required %h", l, g, e);
        end
      end
    end
    clear_queues();
  endtask

  task automatic test_counter();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    clear_queues();
    for (int l = 0; l < N; l++) up_data[l] = W'(8'hE0 + l);
    up_valid = '1;
    tick();
    dn_ready = '1;
    repeat (5) tick();
`ifdef INTF_BRIDGE_XFER_CNT_EN
    checks++;
    if (xfer_cnt !== 16'd20) begin
      errors++;
      $display("FAIL cnt_20: xfer_cnt=%0d required 20", xfer_cnt);
    end
    repeat (16384) tick();
    checks++;
    if (xfer_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_sat: xfer_cnt=%h required ffff", xfer_cnt);
    end
    repeat (3) tick();
    checks++;
    if (xfer_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_hold: xfer_cnt=%h required ffff", xfer_cnt);
    end
`else
    checks++;
    if (xfer_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_off: xfer_cnt=%h required 0000", xfer_cnt);
    end
`endif
    checks++;
    if (got_q[0].size() == 0 || got_q[0][0] !== 8'hE0) begin
      errors++;
      $display("FAIL cnt_stream: first lane0 pop %h required e0",
               got_q[0].size() == 0 ? 8'hxx : got_q[0][0]);
    end
    idle();
    clear_queues();
  endtask

  initial begin
    for (int l = 0; l < N; l++) up_data[l] = '0;
    clear_queues();
    @(negedge clk);
    test_reset();
    test_fill();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
